ysyx_24110015_clint: RTL

- AXI-lite slave holding the 64-bit machine timer (mtime). Sits directly downstream of the CPU-side AXI-lite crossbar, on its CLINT port.
- Decodes two word offsets at CLINT_BASE and CLINT_BASE+4, and returns OKAY or error responses.
- A low-word read latches the high word, so software sees a torn-free 64-bit value when it reads low then high.

---
 rtl/ysyx_24110015_clint_if.sv | 38 +++
 rtl/ysyx_24110015_clint.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_clint_if.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_clint_if
// AXI-lite bundle between the CPU-side crossbar (master) and the CLINT (slave).
//   AR : araddr[31:0], arvalid -> / <- arready
//   R  : <- rdata[31:0], rresp[1:0], rvalid / rready ->
//   AW : awaddr[31:0], awvalid -> / <- awready
//   W  : wdata[31:0], wstrb[3:0], wvalid -> / <- wready
//   B  : <- bresp[1:0], bvalid / bready ->
// ----------------------------------------------------------------------------
interface ysyx_24110015_clint_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_24110015_clint.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_clint
// AXI-lite slave holding the 64-bit machine timer mtime.
//   CLINT_BASE     : mtime[31:0]   (read / byte-strobed write)
//   CLINT_BASE + 4 : mtime[63:32]  (read / byte-strobed write)
// Reading the low word latches the high word into a shadow register so a
// low-then-high read pair returns a torn-free 64-bit value.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : AXI-lite slave modport (AR/R/AW/W/B channels)
// Parameters:
//   CLINT_BASE : byte address of mtime[31:0]
//   TICK_DIV   : clk cycles per mtime increment (>= 1)
// ----------------------------------------------------------------------------
module ysyx_24110015_clint #(
    parameter logic [31:0] CLINT_BASE = 32'ha0000048,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_24110015_clint_if.slave         bus
);

    localparam logic [31:0] HI_ADDR = CLINT_BASE + 32'd4;
    localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_WAIT_W  = 2'd1;
    localparam logic [1:0] W_WAIT_AW = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    logic [63:0]   mtime;
    logic [63:0]   mtime_nxt;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic [31:0]   shadow;
    logic          shadow_vld;

    logic [0:0]    r_state;
    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q;
    logic          ar_fire;
    logic          r_hit_lo;
    logic          r_hit_hi;

    logic [1:0]    w_state;
    logic [31:0]   aw_addr_q;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;
    logic [1:0]    bresp_q;
    logic          w_commit;
    logic [31:0]   w_addr;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic          w_hit_lo;
    logic          w_hit_hi;
    logic          wr_lo;
    logic          wr_hi;
    logic [1:0]    w_resp;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    assign tick = (prescaler == PRE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // A committed write owns the whole counter for that cycle: the written
    // word takes the merged value and neither word increments.
    always_comb begin
        mtime_nxt = tick ? (mtime + 64'd1) : mtime;
        if (wr_lo) begin
            mtime_nxt = {mtime[63:32], byte_merge(mtime[31:0], w_data, w_strb)};
        end else if (wr_hi) begin
            mtime_nxt = {byte_merge(mtime[63:32], w_data, w_strb), mtime[31:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else begin
            mtime <= mtime_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    assign ar_fire  = (r_state == R_IDLE) && bus.arvalid;
    assign r_hit_lo = (bus.araddr == CLINT_BASE);
    assign r_hit_hi = (bus.araddr == HI_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        r_state <= R_DATA;
                        if (r_hit_lo) begin
                            rdata_q <= mtime[31:0];
                            rresp_q <= RESP_OKAY;
                        end else if (r_hit_hi) begin
                            rdata_q <= shadow_vld ? shadow : mtime[63:32];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_DECERR;
                        end
                    end
                end
                default: begin
                    if (bus.rready) r_state <= R_IDLE;
                end
            endcase
        end
    end

    // A low read in the same cycle as a write keeps the pre-write high word
    // and leaves the shadow valid; the read side takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow     <= '0;
            shadow_vld <= 1'b0;
        end else if (ar_fire && r_hit_lo) begin
            shadow     <= mtime[63:32];
            shadow_vld <= 1'b1;
        end else if ((ar_fire && r_hit_hi) || wr_lo || wr_hi) begin
            shadow_vld <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_comb begin
        w_commit = 1'b0;
        w_addr   = bus.awaddr;
        w_data   = bus.wdata;
        w_strb   = bus.wstrb;
        case (w_state)
            W_IDLE:    w_commit = bus.awvalid && bus.wvalid;
            W_WAIT_W: begin
                w_commit = bus.wvalid;
                w_addr   = aw_addr_q;
            end
            W_WAIT_AW: begin
                w_commit = bus.awvalid;
                w_data   = w_data_q;
                w_strb   = w_strb_q;
            end
            default:   w_commit = 1'b0;
        endcase
    end

    assign w_hit_lo = (w_addr == CLINT_BASE);
    assign w_hit_hi = (w_addr == HI_ADDR);
    // An all-zero strobe is acknowledged but touches nothing.
    assign wr_lo    = w_commit && w_hit_lo && (|w_strb);
    assign wr_hi    = w_commit && w_hit_hi && (|w_strb);
    assign w_resp   = (w_hit_lo || w_hit_hi) ? RESP_OKAY : RESP_DECERR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (bus.awvalid && bus.wvalid) begin
                        w_state <= W_RESP;
                        bresp_q <= w_resp;
                    end else if (bus.awvalid) begin
                        w_state   <= W_WAIT_W;
                        aw_addr_q <= bus.awaddr;
                    end else if (bus.wvalid) begin
                        w_state  <= W_WAIT_AW;
                        w_data_q <= bus.wdata;
                        w_strb_q <= bus.wstrb;
                    end
                end
                W_WAIT_W, W_WAIT_AW: begin
                    if (w_commit) begin
                        w_state <= W_RESP;
                        bresp_q <= w_resp;
                    end
                end
                default: begin
                    if (bus.bready) w_state <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.arready = (r_state == R_IDLE);
    assign bus.rvalid  = (r_state == R_DATA);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.awready = (w_state == W_IDLE) || (w_state == W_WAIT_AW);
    assign bus.wready  = (w_state == W_IDLE) || (w_state == W_WAIT_W);
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;

endmodule
